ras_fetch_ctrl: RTL and testbench

Fetch-side return-address predictor front end, directly upstream of the return address stack (RAS). It predecodes each fetched RV32 instruction to classify calls and returns, drives RAS push/pop/data, and forms the predicted next PC. It also keeps a circular checkpoint queue of RAS state per in-flight branch/JALR, which supplies the RAS restore values on a CDB mispredict. Fetch and decode connect through a one-entry valid/ready output register.

---
 rtl/ras_fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ras_fetch_ctrl.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_fetch_ctrl.sv
// Fetch-side return-address predictor front end: predecode, RAS
// push/pop drive, predicted next PC and per-branch RAS checkpoints.
package ras_fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ras_t;
endpackage

module ras_fetch_ctrl
  import ras_fetch_pkg::*;
#(
  parameter int RAS_DEPTH  = 32,
  parameter int CKPT_DEPTH = 8,
  localparam int SPW = $clog2(RAS_DEPTH),
  localparam int TW  = $clog2(CKPT_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_valid,
  output logic           fetch_ready,
  input  logic [31:0]    fetch_pc,
  input  logic [31:0]    fetch_inst,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_pc,
  output logic [31:0]    out_inst,
  output logic [31:0]    out_pred_pc,
  output logic           out_has_ckpt,
  output logic [TW-1:0]  out_ckpt_tag,
  output logic           ras_push,
  output logic           ras_pop,
  output ras_t           ras_din,
  input  ras_t           ras_dout,
  input  logic [SPW-1:0] ras_stack_ptr,
  output ras_t           br_ras_top,
  output logic [SPW-1:0] br_stack_ptr_val,
  input  logic           resolve_mispred,
  input  logic [TW-1:0]  resolve_tag,
  input  logic           ckpt_free
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  function automatic logic link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        is_jal;
  logic        is_jalr;
  logic        is_br;
  logic        is_call;
  logic        is_ret;
  logic        needs_ckpt;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] pc_plus4;
  logic [31:0] pred_pc;

  assign opcode = fetch_inst[6:0];
  assign rd     = fetch_inst[11:7];
  assign rs1    = fetch_inst[19:15];

  assign is_jal     = opcode == OP_JAL;
  assign is_jalr    = opcode == OP_JALR;
  assign is_br      = opcode == OP_BR;
  assign is_call    = (is_jal | is_jalr) & link(rd);
  assign is_ret     = is_jalr & !link(rd) & link(rs1);
  assign needs_ckpt = is_br | is_jalr;

  assign j_imm = {{12{fetch_inst[31]}}, fetch_inst[19:12],
                  fetch_inst[20], fetch_inst[30:21], 1'b0};
  assign b_imm = {{20{fetch_inst[31]}}, fetch_inst[7],
                  fetch_inst[30:25], fetch_inst[11:8], 1'b0};
  assign pc_plus4 = fetch_pc + 32'd4;

  // Backward branches predicted taken, forward not taken.
  always_comb begin
    pred_pc = pc_plus4;
    unique case (1'b1)
      is_jal:                   pred_pc = fetch_pc + j_imm;
      is_br & b_imm[31]:        pred_pc = fetch_pc + b_imm;
      is_ret & ras_dout.valid:  pred_pc = ras_dout.addr;
      default:                  pred_pc = pc_plus4;
    endcase
  end

  logic [TW:0]    head;
  logic [TW:0]    tail;
  logic [TW:0]    count;
  logic [TW:0]    head_nxt;
  logic [TW:0]    tail_nxt;
  logic [TW-1:0]  mis_off;
  logic [TW-1:0]  tail_idx;
  logic           ckpt_full;
  logic           ckpt_empty;
  logic           do_free;
  logic           accept;
  logic           alloc;

  assign count      = tail - head;
  assign ckpt_full  = count == (TW+1)'(CKPT_DEPTH);
  assign ckpt_empty = head == tail;
  assign tail_idx   = tail[TW-1:0];

  assign fetch_ready = !rst & !resolve_mispred &
                       (!out_valid | out_ready) &
                       !(needs_ckpt & ckpt_full);
  assign accept = fetch_valid & fetch_ready;
  assign alloc  = accept & needs_ckpt;

  assign ras_push = accept & is_call;
  assign ras_pop  = accept & is_ret;

  always_comb begin
    ras_din = '0;
    if (ras_push) begin
      ras_din.valid = 1'b1;
      ras_din.addr  = pc_plus4;
    end
  end

  logic [SPW-1:0] ckpt_sp  [CKPT_DEPTH];
  ras_t           ckpt_top [CKPT_DEPTH];
  logic [SPW-1:0] sp_in;
  ras_t           top_in;

  // A checkpointed call is a JALR whose push lands this cycle.
  assign sp_in  = is_call ? ras_stack_ptr + SPW'(1)
                          : ras_stack_ptr;
  assign top_in = is_call ? ras_din : ras_dout;

  always_ff @(posedge clk) begin
    if (alloc) begin
      ckpt_sp[tail_idx]  <= sp_in;
      ckpt_top[tail_idx] <= top_in;
    end
  end

  assign br_stack_ptr_val = ckpt_sp[resolve_tag];
  assign br_ras_top       = ckpt_top[resolve_tag];

  assign do_free  = ckpt_free & !ckpt_empty;
  assign head_nxt = head + {{TW{1'b0}}, do_free};
  assign mis_off  = resolve_tag - head[TW-1:0];

  // Rebuild tail from head so the wrap bit stays consistent.
  always_comb begin
    tail_nxt = tail;
    if (resolve_mispred)
      tail_nxt = head + {1'b0, mis_off} + (TW+1)'(1);
    else if (alloc)
      tail_nxt = tail + (TW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_valid <= 1'b0;
    else if (resolve_mispred)
      out_valid <= 1'b0;
    else if (accept)
      out_valid <= 1'b1;
    else if (out_ready)
      out_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_pc       <= fetch_pc;
      out_inst     <= fetch_inst;
      out_pred_pc  <= pred_pc;
      out_has_ckpt <= needs_ckpt;
      out_ckpt_tag <= tail_idx;
    end
  end

endmodule

// File: tb/tb_ras_fetch_ctrl.sv
// Bench for ras_fetch_ctrl: vector table, directed queue
// sequences and a randomized run against a queue-based model.
module tb_ras_fetch_ctrl;
  import ras_fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] BR_FWD = 32'h0000_0863;
  localparam logic [31:0] ADDI   = 32'h0010_8093;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_pred_pc;
  logic        out_has_ckpt;
  logic [2:0]  out_ckpt_tag;
  logic        ras_push;
  logic        ras_pop;
  ras_t        ras_din;
  ras_t        ras_dout;
  logic [4:0]  ras_stack_ptr;
  ras_t        br_ras_top;
  logic [4:0]  br_stack_ptr_val;
  logic        resolve_mispred;
  logic [2:0]  resolve_tag;
  logic        ckpt_free;

  ras_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_pc(out_pred_pc),
    .out_has_ckpt(out_has_ckpt),
    .out_ckpt_tag(out_ckpt_tag),
    .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_din(ras_din), .ras_dout(ras_dout),
    .ras_stack_ptr(ras_stack_ptr),
    .br_ras_top(br_ras_top),
    .br_stack_ptr_val(br_stack_ptr_val),
    .resolve_mispred(resolve_mispred),
    .resolve_tag(resolve_tag),
    .ckpt_free(ckpt_free)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid     = 1'b0;
    fetch_pc        = '0;
    fetch_inst      = 32'h13;
    out_ready       = 1'b1;
    resolve_mispred = 1'b0;
    resolve_tag     = '0;
    ckpt_free       = 1'b0;
    ras_dout        = '0;
    ras_stack_ptr   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic ras_t mk(input logic v,
                              input logic [31:0] a);
    ras_t r;
    r.valid = v;
    r.addr  = a;
    return r;
  endfunction

  typedef struct {
    bit          call;
    bit          ret;
    bit          ckpt;
    logic [31:0] pred;
  } dec_t;

  // Classification and target straight from the ISA field rules.
  function automatic dec_t decode(input logic [31:0] pc,
                                  input logic [31:0] inst,
                                  input ras_t top);
    dec_t d;
    int op  = int'(inst & 32'h7f);
    int rdn = int'((inst >> 7) & 32'h1f);
    int rsn = int'((inst >> 15) & 32'h1f);
    bit lrd = (rdn == 1) || (rdn == 5);
    bit lrs = (rsn == 1) || (rsn == 5);
    int imm;
    d.call = 0;
    d.ret  = 0;
    d.ckpt = 0;
    d.pred = pc + 32'd4;
    if (op == 'h6f) begin
      imm = int'((inst >> 21) & 32'h3ff) * 2
          + int'((inst >> 20) & 32'h1) * 2048
          + int'((inst >> 12) & 32'hff) * 4096
          - (inst[31] ? 1048576 : 0);
      d.pred = pc + 32'(imm);
      d.call = lrd;
    end else if (op == 'h67) begin
      d.ckpt = 1;
      d.call = lrd;
      d.ret  = !lrd && lrs;
      if (d.ret && top.valid) d.pred = top.addr;
    end else if (op == 'h63) begin
      d.ckpt = 1;
      imm = int'((inst >> 8) & 32'hf) * 2
          + int'((inst >> 25) & 32'h3f) * 32
          + int'((inst >> 7) & 32'h1) * 2048
          - (inst[31] ? 4096 : 0);
      if (imm < 0) d.pred = pc + 32'(imm);
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [4:0]  pick [4];
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    pick[0] = 5'd0;
    pick[1] = 5'd1;
    pick[2] = 5'd5;
    pick[3] = 5'($urandom);
    case (k)
      0:       w[6:0] = 7'h6f;
      1, 2:    w[6:0] = 7'h67;
      3:       w[6:0] = 7'h63;
      4:       w[6:0] = 7'h13;
      default: ;
    endcase
    if (k < 3) begin
      w[11:7]  = pick[$urandom_range(0, 3)];
      w[19:15] = pick[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    ras_t        top;
    logic        push;
    logic        pop;
    logic [31:0] pred;
    logic        ckpt;
  } vec_t;

  typedef struct {
    int         tag;
    logic [4:0] sp;
    ras_t       top;
  } ck_t;

  vec_t tv [14];

  task automatic br_alloc(input logic [31:0] pc,
                          input int exp_tag,
                          input string nm);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = BR_FWD;
    #2;
    chk({nm, "_rdy"}, 64'(fetch_ready), 64'(1));
    tick();
    chk({nm, "_tag"}, 64'(out_ckpt_tag), 64'(exp_tag));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ck_t         q[$];
    int          ntag;
    bit          mv;
    logic [31:0] mpc, minst, mpred;
    bit          mhas;
    int          mtag;
    int          mi;
    bit          acc;
    bit          exp_rdy;
    dec_t        d;

    tv[0]  = '{32'h100, 32'h040000EF, mk(0, 0),
               1, 0, 32'h140, 0};
    tv[1]  = '{32'h104, 32'h00008067, mk(1, 32'h104),
               0, 1, 32'h104, 1};
    tv[2]  = '{32'h200, 32'h00008067, mk(0, 32'hdead),
               0, 1, 32'h204, 1};
    tv[3]  = '{32'h300, 32'h000100E7, mk(1, 32'h77),
               1, 0, 32'h304, 1};
    tv[4]  = '{32'h310, 32'h000280E7, mk(1, 32'h88),
               1, 0, 32'h314, 1};
    tv[5]  = '{32'h320, 32'h000082E7, mk(1, 32'h99),
               1, 0, 32'h324, 1};
    tv[6]  = '{32'h330, 32'h00028067, mk(1, 32'h5550),
               0, 1, 32'h5550, 1};
    tv[7]  = '{32'h340, 32'h00008167, mk(1, 32'h6660),
               0, 1, 32'h6660, 1};
    tv[8]  = '{32'h350, 32'h00010067, mk(1, 32'h7770),
               0, 0, 32'h354, 1};
    tv[9]  = '{32'h400, 32'hFE000CE3, mk(1, 32'h10),
               0, 0, 32'h3F8, 1};
    tv[10] = '{32'h400, BR_FWD, mk(1, 32'h10),
               0, 0, 32'h404, 1};
    tv[11] = '{32'h500, 32'hFFDFF06F, mk(1, 32'h10),
               0, 0, 32'h4FC, 0};
    tv[12] = '{32'h600, ADDI, mk(1, 32'h10),
               0, 0, 32'h604, 0};
    tv[13] = '{32'hFFFFFFFC, 32'h040002EF, mk(0, 0),
               1, 0, 32'h3C, 0};

    idle();
    rst = 1'b1;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    fetch_inst  = 32'h040000EF;
    #2;
    chk("rst_push", 64'(ras_push), 64'(0));
    chk("rst_rdy", 64'(fetch_ready), 64'(0));
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_reset();
      fetch_valid   = 1'b1;
      fetch_pc      = tv[i].pc;
      fetch_inst    = tv[i].inst;
      ras_dout      = tv[i].top;
      ras_stack_ptr = 5'd3;
      #2;
      chk($sformatf("v%0d_rdy", i), 64'(fetch_ready), 64'(1));
      chk($sformatf("v%0d_push", i),
          64'(ras_push), 64'(tv[i].push));
      chk($sformatf("v%0d_pop", i),
          64'(ras_pop), 64'(tv[i].pop));
      if (tv[i].push)
        chk($sformatf("v%0d_din", i), 64'(ras_din),
            64'(mk(1, tv[i].pc + 32'd4)));
      tick();
      fetch_valid = 1'b0;
      chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(1));
      chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(tv[i].pc));
      chk($sformatf("v%0d_pred", i),
          64'(out_pred_pc), 64'(tv[i].pred));
      chk($sformatf("v%0d_has", i),
          64'(out_has_ckpt), 64'(tv[i].ckpt));
      if (tv[i].ckpt)
        chk($sformatf("v%0d_tag", i),
            64'(out_ckpt_tag), 64'(0));
    end

    // Queue full: branches stall, plain ALU ops still flow.
    do_reset();
    for (int k = 0; k < DEPTH; k++)
      br_alloc(32'h1000 + 32'(4 * k), k, "full_fill");
    fetch_inst = BR_FWD;
    #2;
    chk("full_br_stall", 64'(fetch_ready), 64'(0));
    tick();
    fetch_inst = ADDI;
    #2;
    chk("full_addi_rdy", 64'(fetch_ready), 64'(1));
    tick();
    chk("full_addi_out", 64'(out_inst), 64'(ADDI));
    chk("full_addi_has", 64'(out_has_ckpt), 64'(0));
    fetch_inst = BR_FWD;
    ckpt_free  = 1'b1;
    #2;
    chk("full_free_same", 64'(fetch_ready), 64'(0));
    tick();
    ckpt_free = 1'b0;
    br_alloc(32'h2000, 0, "full_wrap");
    fetch_valid = 1'b0;

    // Mispredict on tag 3 of five outstanding.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ras_stack_ptr = 5'(10 + k);
      ras_dout      = mk(1, 32'h2000 + 32'(4 * k));
      br_alloc(32'h3000 + 32'(4 * k), k, "mis_fill");
    end
    resolve_mispred = 1'b1;
    resolve_tag     = 3'd3;
    #2;
    chk("mis_sp", 64'(br_stack_ptr_val), 64'(13));
    chk("mis_top", 64'(br_ras_top), 64'(mk(1, 32'h200C)));
    chk("mis_rdy", 64'(fetch_ready), 64'(0));
    tick();
    resolve_mispred = 1'b0;
    chk("mis_ov", 64'(out_valid), 64'(0));
    br_alloc(32'h4000, 4, "mis_next");
    fetch_valid = 1'b0;

    // Free and mispredict together: count must end at 2.
    do_reset();
    for (int k = 0; k < 4; k++)
      br_alloc(32'h5000 + 32'(4 * k), k, "fm_fill");
    fetch_valid     = 1'b0;
    ckpt_free       = 1'b1;
    resolve_mispred = 1'b1;
    resolve_tag     = 3'd2;
    tick();
    ckpt_free       = 1'b0;
    resolve_mispred = 1'b0;
    for (int k = 0; k < 6; k++)
      br_alloc(32'h6000 + 32'(4 * k), (3 + k) % DEPTH,
               "fm_refill");
    fetch_inst = BR_FWD;
    #2;
    chk("fm_full", 64'(fetch_ready), 64'(0));
    fetch_valid = 1'b0;

    // Call JALR checkpoint holds the post-push pointer and top.
    do_reset();
    ras_stack_ptr = 5'd31;
    ras_dout      = mk(0, 0);
    fetch_valid   = 1'b1;
    fetch_pc      = 32'h300;
    fetch_inst    = 32'h000100E7;
    #2;
    chk("jc_push", 64'(ras_push), 64'(1));
    chk("jc_din", 64'(ras_din), 64'(mk(1, 32'h304)));
    tick();
    fetch_valid = 1'b0;
    chk("jc_pred", 64'(out_pred_pc), 64'(32'h304));
    ras_stack_ptr   = 5'd0;
    ras_dout        = mk(1, 32'hbeef);
    resolve_mispred = 1'b1;
    resolve_tag     = 3'd0;
    #2;
    chk("jc_sp", 64'(br_stack_ptr_val), 64'(0));
    chk("jc_top", 64'(br_ras_top), 64'(mk(1, 32'h304)));
    tick();
    resolve_mispred = 1'b0;

    // Randomized run against the queue model.
    do_reset();
    ntag = 0;
    mv   = 0;
    mhas = 0;
    mtag = 0;
    mpc = 0; minst = 0; mpred = 0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      fetch_valid   = $urandom_range(0, 9) < 7;
      fetch_pc      = $urandom;
      fetch_inst    = rand_inst();
      out_ready     = $urandom_range(0, 9) < 7;
      ras_dout      = mk(1'($urandom), $urandom);
      ras_stack_ptr = 5'($urandom);
      ckpt_free     = $urandom_range(0, 9) < 3;
      resolve_mispred = 1'b0;
      mi = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < 8) begin
        resolve_mispred = 1'b1;
        mi = $urandom_range(0, q.size() - 1);
        resolve_tag = 3'(q[mi].tag);
      end
      #2;
      d = decode(fetch_pc, fetch_inst, ras_dout);
      exp_rdy = !rst && !resolve_mispred && (!mv || out_ready)
                && !(d.ckpt && q.size() == DEPTH);
      acc = fetch_valid && exp_rdy;
      chk("rnd_rdy", 64'(fetch_ready), 64'(exp_rdy));
      chk("rnd_push", 64'(ras_push), 64'(acc && d.call));
      chk("rnd_pop", 64'(ras_pop), 64'(acc && d.ret));
      if (acc && d.call)
        chk("rnd_din", 64'(ras_din),
            64'(mk(1, fetch_pc + 32'd4)));
      if (!rst && resolve_mispred) begin
        chk("rnd_br_sp", 64'(br_stack_ptr_val), 64'(q[mi].sp));
        chk("rnd_br_top", 64'(br_ras_top), 64'(q[mi].top));
      end
      if (rst) begin
        q.delete();
        ntag = 0;
        mv   = 0;
      end else begin
        if (resolve_mispred) begin
          while (q.size() > mi + 1) void'(q.pop_back());
          ntag = (int'(resolve_tag) + 1) % DEPTH;
        end
        if (ckpt_free && q.size() > 0) void'(q.pop_front());
        if (acc && d.ckpt) begin
          ck_t e;
          e.tag = ntag;
          e.sp  = d.call ? ras_stack_ptr + 5'd1 : ras_stack_ptr;
          e.top = d.call ? mk(1, fetch_pc + 32'd4) : ras_dout;
          q.push_back(e);
          mtag = ntag;
          ntag = (ntag + 1) % DEPTH;
        end
        if (resolve_mispred) mv = 0;
        else if (acc) begin
          mv    = 1;
          mpc   = fetch_pc;
          minst = fetch_inst;
          mpred = d.pred;
          mhas  = d.ckpt;
        end else if (out_ready) mv = 0;
      end
      tick();
      chk("rnd_ov", 64'(out_valid), 64'(mv));
      if (mv) begin
        chk("rnd_pc", 64'(out_pc), 64'(mpc));
        chk("rnd_inst", 64'(out_inst), 64'(minst));
        chk("rnd_pred", 64'(out_pred_pc), 64'(mpred));
        chk("rnd_has", 64'(out_has_ckpt), 64'(mhas));
        if (mhas)
          chk("rnd_tag", 64'(out_ckpt_tag), 64'(mtag));
      end
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
